alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 23 ++
 rtl/alu_arbiter_if.sv | 39 +++
 rtl/alu_arb_rr.sv | 32 +++
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the two-port ALU arbiter.
//   state_t         - arbiter FSM state encoding
//   mode_t, MODE_*  - op codes carried unmodified to the shared ALU
//   DEFAULT_TIMEOUT - default WAIT-cycle limit before an op is aborted
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_MUL   = 2'd0;
    localparam mode_t MODE_DIV   = 2'd1;
    localparam mode_t MODE_SHIFT = 2'd2;
    localparam mode_t MODE_AVG   = 2'd3;

    localparam int unsigned DEFAULT_TIMEOUT = 40;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus for two client ports plus the
// issue/completion signals of the shared ALU.
//   slave  - arbiter side: takes requests and ALU completion, drives
//            acks, responses, ALU issue and busy
//   master - environment side (clients and ALU)
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic        req0_valid, req1_valid;
    mode_t       req0_mode,  req1_mode;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ack,   req1_ack;
    logic        rsp0_valid, rsp1_valid;
    logic [63:0] rsp0_data,  rsp1_data;
    logic        rsp0_err,   rsp1_err;
    logic        alu_valid;
    mode_t       alu_mode;
    logic [31:0] alu_in_A, alu_in_B;
    logic        alu_ready;
    logic [63:0] alu_out;
    logic        busy;

    modport slave (
        input  req0_valid, req1_valid, req0_mode, req1_mode,
               req0_a, req0_b, req1_a, req1_b, alu_ready, alu_out,
        output req0_ack, req1_ack, rsp0_valid, rsp1_valid,
               rsp0_data, rsp1_data, rsp0_err, rsp1_err,
               alu_valid, alu_mode, alu_in_A, alu_in_B, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_mode, req1_mode,
               req0_a, req0_b, req1_a, req1_b, alu_ready, alu_out,
        input  req0_ack, req1_ack, rsp0_valid, rsp1_valid,
               rsp0_data, rsp1_data, rsp0_err, rsp1_err,
               alu_valid, alu_mode, alu_in_A, alu_in_B, busy
    );

endinterface

// File: rtl/alu_arb_rr.sv
// alu_arb_rr: two-input round-robin grant.
//   clk, rst    - clock, async active-high reset
//   req0, req1  - request lines
//   update      - record update_port as the last granted port
//   grant       - winning port (0/1), valid when any_req
//   any_req     - at least one request pending
module alu_arb_rr (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic update,
    input  logic update_port,
    output logic grant,
    output logic any_req
);

    logic last_q;

    // Reset to port 1 as "last" so the first contested grant goes to port 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= update_port;
        end
    end

    assign any_req = req0 | req1;
    assign grant   = (req0 && req1) ? ~last_q : req1;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU between two request ports.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - alu_arbiter_if.slave: port requests/acks/responses, ALU issue
//          (alu_valid/mode/in_A/in_B), ALU completion (alu_ready/out), busy
// TIMEOUT bounds the WAIT cycles before an op is aborted with rspN_err.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic        grant_q;
    logic        rr_grant, any_req;
    mode_t       mode_q;
    logic [31:0] a_q, b_q;
    logic [63:0] rsp0_data_q, rsp1_data_q;
    logic        rsp0_err_q, rsp1_err_q;
    logic        at_limit;

    alu_arb_rr u_rr (
        .clk         (clk),
        .rst         (rst),
        .req0        (bus.req0_valid),
        .req1        (bus.req1_valid),
        .update      (state_q == ST_RESP),
        .update_port (grant_q),
        .grant       (rr_grant),
        .any_req     (any_req)
    );

    // Last permitted WAIT cycle: the TIMEOUT-th one without alu_ready.
    assign at_limit = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (bus.alu_ready || at_limit) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            mode_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
            rsp0_err_q  <= 1'b0;
            rsp1_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q <= rr_grant;
                        mode_q  <= rr_grant ? bus.req1_mode : bus.req0_mode;
                        a_q     <= rr_grant ? bus.req1_a    : bus.req0_a;
                        b_q     <= rr_grant ? bus.req1_b    : bus.req0_b;
                    end
                end
                ST_ISSUE: cnt_q <= '0;
                ST_WAIT: begin
                    if (bus.alu_ready) begin
                        if (grant_q) begin
                            rsp1_data_q <= bus.alu_out;
                            rsp1_err_q  <= 1'b0;
                        end else begin
                            rsp0_data_q <= bus.alu_out;
                            rsp0_err_q  <= 1'b0;
                        end
                    end else if (at_limit) begin
                        if (grant_q) begin
                            rsp1_data_q <= '0;
                            rsp1_err_q  <= 1'b1;
                        end else begin
                            rsp0_data_q <= '0;
                            rsp0_err_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Pulses decode from state, so reset clears them with the state register.
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.alu_valid  = (state_q == ST_ISSUE);
    assign bus.req0_ack   = (state_q == ST_ISSUE) && !grant_q;
    assign bus.req1_ack   = (state_q == ST_ISSUE) &&  grant_q;
    assign bus.rsp0_valid = (state_q == ST_RESP)  && !grant_q;
    assign bus.rsp1_valid = (state_q == ST_RESP)  &&  grant_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_data  = rsp1_data_q;
    assign bus.rsp0_err   = rsp0_err_q;
    assign bus.rsp1_err   = rsp1_err_q;
    assign bus.alu_mode   = mode_q;
    assign bus.alu_in_A   = a_q;
    assign bus.alu_in_B   = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus hand-written sequences for
// arbitration order, reset abort and stray alu_ready.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned TO = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- ALU model ----------------
    int unsigned m_delay = 1;
    logic        m_never = 1'b0;
    logic        m_stray = 1'b0;
    logic        m_pend  = 1'b0;
    int unsigned m_cnt   = 0;
    logic [63:0] m_res   = '0;

    function automatic logic [63:0] alu_fn(input mode_t m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            MODE_MUL:   return {32'd0, a} * {32'd0, b};
            MODE_DIV:   return (b == 0) ? 64'd0 : {a % b, a / b};
            MODE_SHIFT: return {32'd0, a >> b[4:0]};
            default:    return ({32'd0, a} + {32'd0, b}) >> 1;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= 1'b0;
        end else if (bus.alu_valid) begin
            m_pend <= 1'b1;
            m_cnt  <= m_delay - 1;
            m_res  <= alu_fn(bus.alu_mode, bus.alu_in_A, bus.alu_in_B);
        end else if (m_pend) begin
            if (m_cnt == 0) m_pend <= 1'b0;
            else m_cnt <= m_cnt - 1;
        end
    end

    assign bus.alu_ready = (m_pend && m_cnt == 0 && !m_never) || m_stray;
    assign bus.alu_out   = m_res;

    // ---------------- pulse counters ----------------
    int unsigned n_ack0 = 0, n_ack1 = 0, n_rsp0 = 0, n_rsp1 = 0, n_issue = 0;
    always @(negedge clk) begin
        if (bus.req0_ack)   n_ack0++;
        if (bus.req1_ack)   n_ack1++;
        if (bus.rsp0_valid) n_rsp0++;
        if (bus.rsp1_valid) n_rsp1++;
        if (bus.alu_valid)  n_issue++;
    end

    // ---------------- checking ----------------
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_mode = '0; bus.req1_mode = '0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    endtask

    task automatic drive(input logic port, input logic v, input mode_t m, input logic [31:0] a, input logic [31:0] b);
        if (port) begin
            bus.req1_valid = v; bus.req1_mode = m; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_mode = m; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},  {63'd0, bus.busy}, 64'd0);
        check({tag, ".pulses"}, {58'd0, bus.req0_ack, bus.req1_ack, bus.rsp0_valid,
                                 bus.rsp1_valid, bus.alu_valid, 1'b0}, 64'd0);
        check({tag, ".rsp0_data"}, bus.rsp0_data, 64'd0);
        check({tag, ".rsp1_data"}, bus.rsp1_data, 64'd0);
        check({tag, ".errs"}, {62'd0, bus.rsp0_err, bus.rsp1_err}, 64'd0);
        check({tag, ".alu_regs"}, {bus.alu_in_A ^ bus.alu_in_B, 30'd0, bus.alu_mode}, 64'd0);
        check({tag, ".alu_in_A"}, {32'd0, bus.alu_in_A}, 64'd0);
    endtask

    typedef struct {
        string       name;
        logic        port;
        mode_t       mode;
        logic [31:0] a, b;
        int unsigned delay;
        logic        never;
        logic [63:0] exp_data;
        logic        exp_err;
        int unsigned exp_lat;
    } vec_t;

    // One transaction from a single port with the DUT idle beforehand.
    task automatic run_vec(input vec_t v);
        int unsigned lat, ack_lat, rsp_lat;
        logic        got_ack, got_rsp;
        logic [63:0] data;
        logic        err;
        int unsigned a0, a1, r0, r1, is;
        m_delay = v.delay;
        m_never = v.never;
        @(posedge clk); #1;
        a0 = n_ack0; a1 = n_ack1; r0 = n_rsp0; r1 = n_rsp1; is = n_issue;
        drive(v.port, 1'b1, v.mode, v.a, v.b);
        lat = 0; ack_lat = 0; rsp_lat = 0; got_ack = 0; got_rsp = 0; data = '0; err = 0;
        while (!got_rsp && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({v.name, ".busy_t"}, {63'd0, bus.busy}, 64'd0);
            if (!got_ack && (v.port ? bus.req1_ack : bus.req0_ack)) begin
                got_ack = 1; ack_lat = lat;
                check({v.name, ".alu_ops"}, {bus.alu_in_A, bus.alu_in_B}, {v.a, v.b});
                check({v.name, ".alu_mode"}, {62'd0, bus.alu_mode}, {62'd0, v.mode});
                check({v.name, ".busy_ack"}, {63'd0, bus.busy}, 64'd1);
                drive(v.port, 1'b0, '0, '0, '0);
            end
            if (v.port ? bus.rsp1_valid : bus.rsp0_valid) begin
                got_rsp = 1; rsp_lat = lat;
                data = v.port ? bus.rsp1_data : bus.rsp0_data;
                err  = v.port ? bus.rsp1_err  : bus.rsp0_err;
                check({v.name, ".busy_rsp"}, {63'd0, bus.busy}, 64'd1);
            end
        end
        check({v.name, ".rsp_seen"}, {63'd0, got_rsp}, 64'd1);
        check({v.name, ".ack_lat"}, 64'(ack_lat), 64'd2);
        check({v.name, ".rsp_lat"}, 64'(rsp_lat), 64'(v.exp_lat));
        check({v.name, ".data"}, data, v.exp_data);
        check({v.name, ".err"}, {63'd0, err}, {63'd0, v.exp_err});
        @(negedge clk);
        check({v.name, ".idle_after"}, {63'd0, bus.busy}, 64'd0);
        check({v.name, ".issue_cnt"}, 64'(n_issue - is), 64'd1);
        check({v.name, ".own_cnt"},
              64'(v.port ? (n_ack1 - a1) + (n_rsp1 - r1) : (n_ack0 - a0) + (n_rsp0 - r0)), 64'd2);
        check({v.name, ".other_cnt"},
              64'(v.port ? (n_ack0 - a0) + (n_rsp0 - r0) : (n_ack1 - a1) + (n_rsp1 - r1)), 64'd0);
    endtask

    vec_t vecs[10];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned lat;
        int unsigned acks_seen, rsps_seen;
        logic        ack_ord[3];
        logic [63:0] rsp_dat[3];
        logic        rsp_ord[3];
        int unsigned r0;
        logic        got;

        vecs[0] = '{"mul3x5",   1'b0, MODE_MUL,   32'd3,        32'd5,        32, 1'b0, 64'd15,                 1'b0, 35};
        vecs[1] = '{"avg6_9",   1'b1, MODE_AVG,   32'd6,        32'd9,        1,  1'b0, 64'd7,                  1'b0, 4};
        vecs[2] = '{"mul_max",  1'b0, MODE_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 2,  1'b0, 64'hFFFFFFFE_00000001,  1'b0, 5};
        vecs[3] = '{"div100_7", 1'b1, MODE_DIV,   32'd100,      32'd7,        5,  1'b0, 64'h00000002_0000000E,  1'b0, 8};
        vecs[4] = '{"shr80_3",  1'b0, MODE_SHIFT, 32'h80,       32'd3,        1,  1'b0, 64'h10,                 1'b0, 4};
        vecs[5] = '{"avg_wrap", 1'b1, MODE_AVG,   32'hFFFFFFFF, 32'd1,        1,  1'b0, 64'h80000000,           1'b0, 4};
        vecs[6] = '{"tmo_p0",   1'b0, MODE_MUL,   32'd7,        32'd9,        1,  1'b1, 64'd0,                  1'b1, TO + 3};
        vecs[7] = '{"after_to", 1'b0, MODE_SHIFT, 32'hF0,       32'd4,        1,  1'b0, 64'hF,                  1'b0, 4};
        vecs[8] = '{"rdy_at40", 1'b1, MODE_MUL,   32'h10000,    32'h10000,    TO, 1'b0, 64'h1_00000000,         1'b0, TO + 3};
        vecs[9] = '{"tmo_p1",   1'b1, MODE_DIV,   32'd9,        32'd3,        1,  1'b1, 64'd0,                  1'b1, TO + 3};

        idle_inputs();
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Simultaneous requests; port 0 re-requests right after its ack so the
        // second arbitration is contested again and must favour port 1.
        m_delay = 1; m_never = 0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, MODE_DIV,   32'd100, 32'd7);
        drive(1'b1, 1'b1, MODE_SHIFT, 32'h80,  32'd3);
        acks_seen = 0; rsps_seen = 0; lat = 0;
        while (rsps_seen < 3 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.req0_ack || bus.req1_ack) begin
                if (acks_seen < 3) ack_ord[acks_seen] = bus.req1_ack;
                if (bus.req1_ack) drive(1'b1, 1'b0, '0, '0, '0);
                else if (acks_seen == 0) drive(1'b0, 1'b1, MODE_AVG, 32'd2, 32'd4);
                else drive(1'b0, 1'b0, '0, '0, '0);
                acks_seen++;
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (rsps_seen < 3) begin
                    rsp_ord[rsps_seen] = bus.rsp1_valid;
                    rsp_dat[rsps_seen] = bus.rsp1_valid ? bus.rsp1_data : bus.rsp0_data;
                end
                rsps_seen++;
            end
        end
        idle_inputs();
        check("pair.rsp_count", 64'(rsps_seen), 64'd3);
        check("pair.ack_count", 64'(acks_seen), 64'd3);
        check("pair.ack_order", {61'd0, ack_ord[0], ack_ord[1], ack_ord[2]}, 64'b010);
        check("pair.rsp_order", {61'd0, rsp_ord[0], rsp_ord[1], rsp_ord[2]}, 64'b010);
        check("pair.div", rsp_dat[0], 64'h00000002_0000000E);
        check("pair.shift", rsp_dat[1], 64'h10);
        check("pair.avg", rsp_dat[2], 64'd3);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset pulsed mid-WAIT of a long mul aborts it without a response.
        m_delay = 32; m_never = 0;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, MODE_MUL, 32'd11, 32'd13);
        got = 0; lat = 0;
        while (!got && lat < 20) begin
            @(negedge clk); lat++;
            if (bus.req0_ack) got = 1;
        end
        check("rstmid.ack", {63'd0, got}, 64'd1);
        drive(1'b0, 1'b0, '0, '0, '0);
        r0 = n_rsp0 + n_rsp1;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("rstmid");
        #5 rst = 1'b0;
        repeat (40) @(posedge clk);
        check("rstmid.no_rsp", 64'(n_rsp0 + n_rsp1 - r0), 64'd0);
        run_vec('{"post_rst", 1'b0, MODE_SHIFT, 32'hF0, 32'd4, 1, 1'b0, 64'hF, 1'b0, 4});

        // Stray alu_ready with a stale, distinct alu_out while idle.
        @(posedge clk); #1;
        r0 = n_rsp0 + n_rsp1;
        m_stray = 1'b1;
        @(posedge clk); #1;
        m_stray = 1'b0;
        repeat (2) @(posedge clk);
        check("stray.no_rsp", 64'(n_rsp0 + n_rsp1 - r0), 64'd0);
        check("stray.idle", {63'd0, bus.busy}, 64'd0);
        run_vec('{"mul2x2", 1'b0, MODE_MUL, 32'd2, 32'd2, 3, 1'b0, 64'd4, 1'b0, 6});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
